// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues req/ack reads at pc_curr, buffers fetched
// instructions with their PC in an IF/ID FIFO, stalls the PC while a fetch is
// outstanding or the buffer is full, and drops wrong-path work on flush.
// Optional statistics counters are enabled with `define FETCH_STATS_EN.
module fetch_stage #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_curr,
  output logic               pc_stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_ready,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_fetch,
  output logic [15:0]        stat_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   cnt_after_pop;
  logic [PC_W-1:0]    kill_addr_q;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic               pop;
  logic               push;
  logic               kill_load;

  // Entry 0 is always the head, so the outputs come straight from it; when the
  // buffer drains nothing shifts over entry 0 and it keeps the last head.
  assign ifid_valid    = (count_q != '0);
  assign pop           = ifid_valid & id_ready;
  assign cnt_after_pop = count_q - CNT_W'(pop);
  assign ifid_instr    = instr_mem[0];
  assign ifid_pc       = pc_mem[0];
  assign ifid_pc_plus4 = ifid_pc + PC_W'(4);

  // Next-state, memory request and PC stall decode.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    imem_addr = pc_curr;
    push      = 1'b0;
    kill_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush || (cnt_after_pop < DEPTH_C)) state_d = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (!flush) begin
            push    = 1'b1;
            state_d = ((cnt_after_pop + CNT_W'(1)) < DEPTH_C) ? WAIT : IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (flush) begin
          kill_load = 1'b1;
          state_d   = KILL;
        end
      end
      KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_q;
        if (imem_ack) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
    pc_stall = !(flush | ((state_q == WAIT) & imem_ack));
  end

  // State, occupancy and wrong-path address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      kill_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) count_q <= '0;
      else       count_q <= cnt_after_pop + CNT_W'(push);
      if (kill_load) kill_addr_q <= pc_curr;
    end
  end

  // Shift-down FIFO storage: pop moves valid entries toward the head, push
  // lands in the first free slot after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (!flush) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (pop && (CNT_W'(i + 1) < count_q)) begin
          instr_mem[i] <= instr_mem[i + 1];
          pc_mem[i]    <= pc_mem[i + 1];
        end
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && (CNT_W'(i) == cnt_after_pop)) begin
          instr_mem[i] <= imem_rdata;
          pc_mem[i]    <= pc_curr;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating fetch and stall-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetch <= '0;
      stat_stall <= '0;
    end else begin
      if (push && (stat_fetch != '1))     stat_fetch <= stat_fetch + 16'd1;
      if (pc_stall && (stat_stall != '1)) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a PC model and a
// configurable-latency instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  pc_curr;
  logic        pc_stall;
  logic        flush;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_pc;
  logic [5:0]  ifid_pc_plus4;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetch;
  logic [15:0] stat_stall;
`endif

  int unsigned mem_wait;
  logic        man_mode;
  logic        man_ack;
  logic [31:0] wcnt;
  logic [5:0]  jump_target;
  int          checks = 0;
  int          errors = 0;

  fetch_stage #(.PC_W(6), .INSTR_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_curr(pc_curr), .pc_stall(pc_stall),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4)
`ifdef FETCH_STATS_EN
    , .stat_fetch(stat_fetch), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Program counter: jump wins, otherwise advance by 4 unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc_curr <= '0;
    else if (flush)     pc_curr <= jump_target;
    else if (!pc_stall) pc_curr <= pc_curr + 6'd4;
  end

  // Memory wait counter: cycles the current request has been held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wcnt <= '0;
    else if (!imem_req || imem_ack) wcnt <= '0;
    else                            wcnt <= wcnt + 32'd1;
  end

  // Memory returns 0xA0000000 + address.
  always_comb begin
    imem_ack   = man_mode ? man_ack : (imem_req && (wcnt >= mem_wait));
    imem_rdata = 32'hA000_0000 | {26'd0, imem_addr};
  end

  task automatic reset_dut(input int unsigned w, input logic manual, input logic rdy);
    rst_n = 1'b0; flush = 1'b0; jump_target = '0; man_ack = 1'b0;
    mem_wait = w; man_mode = manual; id_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; id_ready = 1'b1; man_mode = 1'b0; man_ack = 1'b0;
    mem_wait = 0; jump_target = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 00000000", ifid_instr); end
    checks++; if (ifid_pc !== 6'd0) begin errors++; $display("FAIL rst_pc: got %0d expected 0", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 6'd4) begin errors++; $display("FAIL rst_pc_plus4: got %0d expected 4", ifid_pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b expected 1", pc_stall); end
  endtask

  task automatic test_zero_wait();
    logic [5:0] ep;
    reset_dut(0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_first_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL zw_first_addr: got %0d expected 0", imem_addr); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL zw_first_stall: got %b expected 0", pc_stall); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b expected 0", ifid_valid); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ep = 6'(4 * i);
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b expected 1", i, ifid_valid); end
      checks++; if (ifid_pc !== ep) begin errors++; $display("FAIL zw_pc[%0d]: got %0d expected %0d", i, ifid_pc, ep); end
      checks++; if (ifid_instr !== (32'hA000_0000 + 32'(ep))) begin errors++; $display("FAIL zw_instr[%0d]: got %h expected %h", i, ifid_instr, 32'hA000_0000 + 32'(ep)); end
      checks++; if (ifid_pc_plus4 !== 6'(ep + 6'd4)) begin errors++; $display("FAIL zw_plus4[%0d]: got %0d expected %0d", i, ifid_pc_plus4, 6'(ep + 6'd4)); end
    end
    checks++; if (ifid_pc !== 6'd60) begin errors++; $display("FAIL zw_wrap_pc: got %0d expected 60", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 6'd0) begin errors++; $display("FAIL zw_wrap_plus4: got %0d expected 0", ifid_pc_plus4); end
  endtask

  task automatic test_mem_wait();
    reset_dut(2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL mw_stall1[%0d]: got %b expected 1", k, pc_stall); end
      checks++; if (ifid_valid !== (k > 0)) begin errors++; $display("FAIL mw_valid1[%0d]: got %b expected %b", k, ifid_valid, k > 0); end
      if (k > 0) begin
        checks++; if (ifid_pc !== 6'(4 * (k - 1))) begin errors++; $display("FAIL mw_pc[%0d]: got %0d expected %0d", k, ifid_pc, 4 * (k - 1)); end
      end
      @(negedge clk);
      checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL mw_stall2[%0d]: got %b expected 1", k, pc_stall); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mw_valid2[%0d]: got %b expected 0", k, ifid_valid); end
      @(negedge clk);
      checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL mw_stall3[%0d]: got %b expected 0", k, pc_stall); end
      checks++; if (imem_addr !== 6'(4 * k)) begin errors++; $display("FAIL mw_addr[%0d]: got %0d expected %0d", k, imem_addr, 4 * k); end
    end
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL mw_last_valid: got %b expected 1", ifid_valid); end
    checks++; if (ifid_pc !== 6'd8) begin errors++; $display("FAIL mw_last_pc: got %0d expected 8", ifid_pc); end
  endtask

  task automatic test_full();
    reset_dut(0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL full_w1_stall: got %b expected 0", pc_stall); end
    @(negedge clk);
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL full_w2_addr: got %0d expected 4", imem_addr); end
    checks++; if (ifid_pc !== 6'd0) begin errors++; $display("FAIL full_w2_pc: got %0d expected 0", ifid_pc); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req[%0d]: got %b expected 0", c, imem_req); end
      checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL full_stall[%0d]: got %b expected 1", c, pc_stall); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL full_valid[%0d]: got %b expected 1", c, ifid_valid); end
      checks++; if (ifid_pc !== 6'd0) begin errors++; $display("FAIL full_head[%0d]: got %0d expected 0", c, ifid_pc); end
    end
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (ifid_pc !== 6'd4) begin errors++; $display("FAIL full_drain1: got %0d expected 4", ifid_pc); end
    checks++; if (ifid_instr !== 32'hA000_0004) begin errors++; $display("FAIL full_drain1_instr: got %h expected a0000004", ifid_instr); end
    @(negedge clk);
    checks++; if (ifid_pc !== 6'd8) begin errors++; $display("FAIL full_drain2: got %0d expected 8", ifid_pc); end
  endtask

  task automatic test_flush_kill();
    reset_dut(0, 1'b1, 1'b0);
    @(negedge clk);
    man_ack = 1'b1;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fk_ack_stall: got %b expected 0", pc_stall); end
    @(negedge clk);
    man_ack = 1'b0; jump_target = 6'h20; flush = 1'b1;
    #1;
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL fk_pre_valid: got %b expected 1", ifid_valid); end
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL fk_pre_addr: got %0d expected 4", imem_addr); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fk_flush_stall: got %b expected 0", pc_stall); end
    @(negedge clk);
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fk_empty: got %b expected 0", ifid_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fk_kill_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL fk_kill_addr: got %0d expected 4", imem_addr); end
    flush = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL fk_kill_hold: got %0d expected 4", imem_addr); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL fk_kill_stall: got %b expected 1", pc_stall); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fk_late_dropped: got %b expected 0", ifid_valid); end
    checks++; if (imem_addr !== 6'h20) begin errors++; $display("FAIL fk_target_addr: got %h expected 20", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fk_target_req: got %b expected 1", imem_req); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    checks++; if (ifid_pc !== 6'h20) begin errors++; $display("FAIL fk_target_pc: got %h expected 20", ifid_pc); end
    checks++; if (ifid_instr !== 32'hA000_0020) begin errors++; $display("FAIL fk_target_instr: got %h expected a0000020", ifid_instr); end
  endtask

  task automatic test_flush_ack();
    reset_dut(0, 1'b0, 1'b1);
    @(negedge clk);
    flush = 1'b1; jump_target = 6'h20;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fa_stall: got %b expected 0", pc_stall); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fa_dropped: got %b expected 0", ifid_valid); end
    checks++; if (imem_addr !== 6'h20) begin errors++; $display("FAIL fa_target_addr: got %h expected 20", imem_addr); end
    @(negedge clk);
    checks++; if (ifid_pc !== 6'h20) begin errors++; $display("FAIL fa_target_pc: got %h expected 20", ifid_pc); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL fa_target_valid: got %b expected 1", ifid_valid); end
  endtask

  task automatic test_reset_mid();
    reset_dut(0, 1'b1, 1'b0);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b expected 1", ifid_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_pre_req: got %b expected 1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rm_instr: got %h expected 00000000", ifid_instr); end
    checks++; if (ifid_pc !== 6'd0) begin errors++; $display("FAIL rm_pc: got %0d expected 0", ifid_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", imem_req); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rm_stall: got %b expected 1", pc_stall); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_full();
    test_flush_kill();
    test_flush_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly downstream of the program counter. It fetches the word at `pc_curr` from instruction memory over a req/ack handshake and buffers fetched instructions with their PC in a small FIFO that forms the IF/ID interface. It holds the PC through `pc_stall` while a fetch is outstanding or the buffer is full, and drops wrong-path work on `flush`.

## Interface
- `PC_W`, 6: PC / instruction-memory byte-address width.
- `INSTR_W`, 32: instruction width.
- `DEPTH`, 2: IF/ID buffer entries, at least 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pc_curr`  in  PC_W  current PC from the program counter.
- `pc_stall`  out  1  stall to the program counter: hold the PC when 1.
- `flush`  in  1  jump taken this cycle; the same signal drives the PC's `jump_cs`.
- `imem_req`  out  1  instruction-memory read request, level.
- `imem_addr`  out  PC_W  read address, stable while `imem_req`=1.
- `imem_ack`  in  1  read data valid; may arrive in the same cycle as `imem_req`.
- `imem_rdata`  in  INSTR_W  read data, sampled when `imem_req & imem_ack`.
- `id_ready`  in  1  decode accepts the head entry.
- `ifid_valid`  out  1  buffer non-empty.
- `ifid_instr`  out  INSTR_W  head instruction.
- `ifid_pc`  out  PC_W  head PC.
- `ifid_pc_plus4`  out  PC_W  `ifid_pc`+4, modulo 2^PC_W.

## Operation
- FSM states are IDLE, WAIT and KILL. Reset state is IDLE.
- `pop = ifid_valid & id_ready`. `space` is 1 when count - pop + push < DEPTH, evaluated at the edge.
- **IDLE:** `imem_req`=0 and `pc_stall`=1 unless `flush`.
  - Go to WAIT when `flush` is 1, or when count - pop < DEPTH.
- **WAIT:** `imem_req`=1 and `imem_addr`=`pc_curr`. The PC is stalled, so the address is stable.
  - ack with no `flush`: push {`pc_curr`, `imem_rdata`} and let the PC advance (`pc_stall`=0). Go to WAIT if `space`, else IDLE.
  - ack with `flush`: discard the data and go to WAIT. The next request uses the jump target.
  - `flush` with no ack: latch `pc_curr` into `kill_addr` and go to KILL.
- **KILL:** `imem_req`=1 and `imem_addr`=`kill_addr`.
  - On ack, discard the data and go to WAIT.
  - A further `flush` in KILL stays in KILL and does not reload `kill_addr`.
- `pc_stall` = !(`flush` | (state==WAIT & `imem_ack`)). It is forced to 0 on `flush`, because the PC gives stall priority over jump.
- FIFO: push and pop are allowed in the same cycle, including when full. A pop on empty is ignored.
- `flush` empties the FIFO at the edge (count to 0) and takes priority over push and pop.
- `ifid_*` show the head entry. When empty they hold the last head values, and are 0 after reset.

## Timing
- Reset (async assert) forces:
  - state IDLE, count 0
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc`=0, `kill_addr`=0
  - `imem_req`=0, `pc_stall`=1
- Release is synchronous to the next edge. First cycle after release: IDLE, then WAIT on the following edge.
- Latency: an ack at edge N makes `ifid_valid`=1 from cycle N+1, with the PC equal to `pc_curr` at N.
- With a zero-wait memory (ack tied to 1) and `id_ready`=1, throughput is one instruction per cycle after the first IDLE cycle.
- Each extra memory wait cycle adds one cycle.
- Full buffer with `id_ready`=0: the block sits in IDLE with `pc_stall`=1 and no request outstanding.
- A wrong-path request in flight at `flush` costs the remaining wait cycles plus one before the target fetch is issued.
- Reset asserted mid-request abandons the transaction. The memory must tolerate `imem_req` dropping without an ack.

## Configuration
- `FETCH_STATS_EN` defined adds two output ports, each reset to 0 and saturating at all-ones:
  - `stat_fetch`  out  16  count of pushed instructions.
  - `stat_stall`  out  16  count of cycles with `pc_stall`=1.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Zero-wait memory (ack=1), `id_ready`=1, `pc_curr` from a PC starting at 0:
  - `ifid_pc` runs 0, 4, 8, 12 on consecutive cycles with `ifid_pc_plus4` = `ifid_pc`+4.
  - `ifid_pc`=60 gives `ifid_pc_plus4`=0.
- Memory acks 2 cycles after req: `pc_stall`=1 for 2 cycles per fetch, and one instruction arrives every 3 cycles.
- `id_ready`=0 with DEPTH=2: after two pushes, `imem_req`=0 and `pc_stall`=1. Raising `id_ready` drains entry 0 and then entry 1 in order.
- `flush` with a request pending and no ack:
  - FSM enters KILL, `imem_addr` holds the old PC and the FIFO is empty next cycle.
  - The late ack's data is never shown. The next request is at the jump target, e.g. 0x20.
- `flush` and `imem_ack` in the same cycle: the data is dropped, `pc_stall`=0, and the next request goes straight to the target.
- `rst_n` dropped mid-WAIT with the FIFO holding 1 entry: all outputs go to reset values immediately, with no clock edge needed.
